// File: rtl/timer_down_prog_pkg.sv
// Shared definitions for the programmable down-counting timer: FSM states,
// mode encodings and the bit-width helper used to size the prescaler.
package timer_down_prog_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Bits needed to hold value; a value of 0 still needs one bit.
  function automatic int wordlength(input int unsigned value);
    int bits;
    bits = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/timer_down_prog_if.sv
// Control and status bundle of the timer; the controller drives the master
// side and the timer itself sits on the slave side.
interface timer_down_prog_if #(
  parameter int WIDTH = 16
);
  logic             turbosim;
  logic             start;
  logic             stop;
  logic             hold;
  logic             rld;
  logic             mode;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             underflow;
  logic             done;

  modport master (
    output turbosim, start, stop, hold, rld, mode, load_value,
    input  count, running, underflow, done
  );

  modport slave (
    input  turbosim, start, stop, hold, rld, mode, load_value,
    output count, running, underflow, done
  );
endinterface

// File: rtl/timer_down_prog_prescaler_tick.sv
// Clock prescaler: counts down while enabled and flags a tick on the cycle it
// sits at zero, reloading from the normal or turbosim period.
module prescaler_tick
  import timer_down_prog_pkg::*;
#(
  parameter int PRESCALE_MAX          = 99,
  parameter int PRESCALE_MAX_TURBOSIM = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_reload,
  input  logic i_turbosim,
  output logic o_tick
);

  localparam int unsigned PRESC_TOP =
    (PRESCALE_MAX > PRESCALE_MAX_TURBOSIM) ? PRESCALE_MAX : PRESCALE_MAX_TURBOSIM;
  localparam int PW = wordlength(PRESC_TOP);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_reloadVal;

  // The period select is looked at on every reload, so turbosim can change live.
  assign w_reloadVal = i_turbosim ? PW'(PRESCALE_MAX_TURBOSIM) : PW'(PRESCALE_MAX);
  assign o_tick      = i_en && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= w_reloadVal;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= w_reloadVal;
      else             r_cnt <= r_cnt - PW'(1);
    end
  end

endmodule

// File: rtl/timer_down_prog.sv
// Programmable down-counting timer with prescaler, periodic/one-shot modes,
// a registered one-cycle underflow pulse and a sticky one-shot done flag.
module timer_down_prog
  import timer_down_prog_pkg::*;
#(
  parameter int WIDTH                 = 16,
  parameter int PRESCALE_MAX          = 99,
  parameter int PRESCALE_MAX_TURBOSIM = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  timer_down_prog_if.slave  bus
);

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_count, w_countNext;
  logic [WIDTH-1:0] r_reloadReg, w_reloadNext;
  logic             r_mode, w_modeNext;
  logic             r_done, w_doneNext;
  logic             r_underflow, w_underflowNext;
  logic             w_presEn;
  logic             w_presReload;
  logic             w_tick;

  assign w_presEn = (r_state == ST_RUN) && !bus.hold;

  prescaler_tick #(
    .PRESCALE_MAX          (PRESCALE_MAX),
    .PRESCALE_MAX_TURBOSIM (PRESCALE_MAX_TURBOSIM)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_presEn),
    .i_reload   (w_presReload),
    .i_turbosim (bus.turbosim),
    .o_tick     (w_tick)
  );

  // Event priority is stop > start > rld > tick; a lower event is dropped when
  // a higher one fires in the same cycle, which also suppresses underflow.
  always_comb begin
    w_stateNext     = r_state;
    w_countNext     = r_count;
    w_reloadNext    = r_reloadReg;
    w_modeNext      = r_mode;
    w_doneNext      = r_done;
    w_underflowNext = 1'b0;
    w_presReload    = 1'b0;

    if (bus.stop) begin
      w_stateNext = ST_IDLE;
      w_countNext = '0;
    end else if (bus.start) begin
      w_stateNext  = ST_RUN;
      w_countNext  = bus.load_value;
      w_reloadNext = bus.load_value;
      w_modeNext   = bus.mode;
      w_doneNext   = 1'b0;
      w_presReload = 1'b1;
    end else if (bus.rld && (r_state == ST_RUN)) begin
      w_countNext  = bus.load_value;
      w_reloadNext = bus.load_value;
      w_presReload = 1'b1;
    end else if (w_tick) begin
      if (r_count != '0) begin
        w_countNext = r_count - WIDTH'(1);
      end else begin
        w_underflowNext = 1'b1;
        if (r_mode == MODE_ONESHOT) begin
          w_stateNext = ST_IDLE;
          w_doneNext  = 1'b1;
        end else begin
          w_countNext = r_reloadReg;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_reloadReg <= '0;
      r_mode      <= MODE_PERIODIC;
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_count     <= w_countNext;
      r_reloadReg <= w_reloadNext;
      r_mode      <= w_modeNext;
      r_done      <= w_doneNext;
      r_underflow <= w_underflowNext;
    end
  end

  assign bus.count     = r_count;
  assign bus.running   = (r_state == ST_RUN);
  assign bus.underflow = r_underflow;
  assign bus.done      = r_done;

endmodule

// File: doc/timer_down_prog.md
Name: timer_down_prog

Overview:
Programmable down-counting timer, the parametrised successor of the fixed-period reload counter. It has a runtime load value, a parametrised prescaler, periodic or one-shot mode, and start/stop/hold/reload controls. It emits a one-cycle underflow pulse and a sticky done flag. It sits beside display/scan logic and FSMs as their general-purpose tick and timeout source.

Parameters:
WIDTH, 16, bit width of the count and load_value.
PRESCALE_MAX, 99, prescaler reload value; one tick every (PRESCALE_MAX+1) clocks; 0 means a tick every clock.
PRESCALE_MAX_TURBOSIM, 1, prescaler reload value used when turbosim=1.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset_n  in  1  asynchronous active-low reset.
turbosim  in  1  selects PRESCALE_MAX_TURBOSIM for the prescaler reload.
start  in  1  pulse; loads load_value and enters RUN.
stop  in  1  pulse; aborts to IDLE.
hold  in  1  level; freezes the prescaler and count while in RUN.
rld  in  1  pulse; reloads load_value while in RUN.
mode  in  1  0 = periodic, 1 = one-shot; sampled at start.
load_value  in  WIDTH  reload count.
count  out  WIDTH  current count.
running  out  1  high in RUN.
underflow  out  1  one-cycle pulse when count expires.
done  out  1  sticky; one-shot expiry.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, count=0, reload_reg=0, prescaler=0.
  - underflow=0, done=0, running=0, mode_reg=0.
- States:
  - IDLE: count holds; prescaler idle.
  - RUN: running=1.
- Prescaler reload value:
  - turbosim ? PRESCALE_MAX_TURBOSIM : PRESCALE_MAX.
  - Sampled at every prescaler reload.
- tick = (state==RUN) && !hold && (prescaler==0). tick is combinational and internal.
- Prescaler in RUN, !hold:
  - prescaler==0: reload.
  - otherwise: decrement.
- Priority each cycle: stop > start > rld > tick.
- stop (any state):
  - -> IDLE, count=0.
  - underflow is not asserted; done is unchanged.
- start (any state):
  - count=load_value, reload_reg=load_value, mode_reg=mode.
  - prescaler reloaded, done=0, -> RUN.
  - start while already in RUN restarts the timer.
- rld in RUN:
  - count=load_value, reload_reg=load_value, prescaler reloaded.
  - No underflow, even if a tick coincides.
- rld in IDLE: ignored.
- tick with count!=0: count=count-1.
- tick with count==0: underflow=1 on the next cycle, then:
  - mode_reg=0 (periodic): count=reload_reg, stay in RUN.
  - mode_reg=1 (one-shot): -> IDLE, count stays 0, done=1.
- underflow is a registered single-cycle pulse and is 0 on every other cycle.
- Period = (reload_reg+1)*(prescale+1) clocks.
  - The first underflow is high exactly one period after the start edge.
  - load_value=0 gives an underflow every (prescale+1) clocks.
- hold: prescaler and count frozen, state unchanged.
  - stop, start and rld still act during hold.
- load_value changes after start/rld do not affect a periodic reload; only reload_reg is used.
- Arithmetic:
  - Unsigned, WIDTH bits. The decrement never wraps because count==0 always reloads or stops.
  - Prescaler width = wordlength(max(PRESCALE_MAX, PRESCALE_MAX_TURBOSIM)).
- Reset asserted mid-run: immediate return to reset values, with no underflow pulse.

Decomposition:
- Shared include header holds:
  - the wordlength function;
  - the timing include;
  - state encodings ST_IDLE=1'b0 and ST_RUN=1'b1;
  - MODE_PERIODIC=0 and MODE_ONESHOT=1.
- One sub-module: prescaler_tick, a down-counter with enable, a synchronous reload input, a turbosim select and a tick output.
- timer_down_prog instantiates prescaler_tick and holds the FSM, count, reload_reg and output registers.

Test Plan:
(All scenarios use WIDTH=8, PRESCALE_MAX=3, PRESCALE_MAX_TURBOSIM=0, turbosim=0 unless stated.)
1. Periodic: mode=0, load_value=4, start at t0 -> underflow high at t0+20, t0+40, t0+60, each exactly 1 cycle; done=0; running=1.
2. One-shot: mode=1, load_value=2, start -> single underflow at t0+12; then running=0, done=1, count=0; no further pulses over 50 cycles.
3. Hold: periodic load_value=4, hold high for 5 cycles starting at t0+7 -> first underflow at t0+25; count is frozen during hold.
4. Priority: in RUN at count==0 with a tick due, assert rld with load_value=9 -> no underflow, count=9. Assert stop and start together -> state IDLE, count=0.
5. Async reset: reset_n low mid-run between clock edges -> count=0, running=0, underflow=0, done=0 immediately. After release, start with load_value=1 -> underflow at +8.
6. Turbosim=1, periodic, load_value=3 -> underflow every 4 cycles. load_value=0 -> underflow every cycle.
